// File: rtl/mux_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : mux_rr_scheduler
// Brief    : Round-robin burst scheduler driving the select of a 31:1 mux,
//            with a valid/ready handshake toward a single consumer.
// Revision : 1.0 - initial release
// ============================================================================
module mux_rr_scheduler #(
  parameter int               NUM_REQ  = 31,
  parameter int               SEL_W    = 5,
  parameter int               HOLD_W   = 2,
  parameter logic [SEL_W-1:0] IDLE_SEL = 5'b11111
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               arb_en,
  input  logic [HOLD_W-1:0]  cfg_hold,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   sel,
  output logic [NUM_REQ-1:0] gnt,
  output logic               out_valid,
  output logic               burst_done
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t             r_state;
  logic [SEL_W-1:0]   r_sel;
  logic [SEL_W-1:0]   r_ptr;
  logic [NUM_REQ-1:0] r_gnt;
  logic               r_valid;
  logic [HOLD_W-1:0]  r_beat_cnt;
  logic [HOLD_W-1:0]  r_hold_q;

  logic               w_cur_req;
  logic               w_accept;
  logic               w_last;
  logic               w_grant_ok;
  logic               w_load;
  logic               w_to_idle;
  logic [NUM_REQ-1:0] w_cand;
  logic               w_found;
  logic [SEL_W-1:0]   w_winner;
  logic [SEL_W-1:0]   w_next_ptr;
  int                 w_idx;

  // r_gnt is zero outside GRANT, so this is req[sel] only while a burst is live
  assign w_cur_req = |(req & r_gnt);
  assign w_accept  = r_valid & out_ready;
  assign w_last    = w_accept & (r_beat_cnt == r_hold_q) & w_cur_req;

  // The current grantee is only ever unmasked while idle, which forces a
  // single-requester stream through one idle bubble between bursts.
  assign w_cand = (r_state == ST_GRANT) ? (req & ~r_gnt) : req;

  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (!w_found && w_cand[w_idx]) begin
        w_found  = 1'b1;
        w_winner = SEL_W'(w_idx);
      end
    end
  end

  assign w_grant_ok = w_found & arb_en;
  assign w_next_ptr = (w_winner == SEL_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;

  assign w_load    = ((r_state == ST_IDLE) & w_grant_ok) |
                     ((r_state == ST_GRANT) & w_last & w_grant_ok);
  assign w_to_idle = (r_state == ST_GRANT) & (~w_cur_req | (w_last & ~w_grant_ok));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_sel      <= IDLE_SEL;
      r_gnt      <= '0;
      r_valid    <= 1'b0;
      r_ptr      <= '0;
      r_beat_cnt <= '0;
      r_hold_q   <= '0;
    end else if (w_load) begin
      r_state    <= ST_GRANT;
      r_sel      <= w_winner;
      r_gnt      <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_winner;
      r_valid    <= 1'b1;
      r_ptr      <= w_next_ptr;
      r_beat_cnt <= '0;
      r_hold_q   <= cfg_hold;
    end else if (w_to_idle) begin
      r_state    <= ST_IDLE;
      r_sel      <= IDLE_SEL;
      r_gnt      <= '0;
      r_valid    <= 1'b0;
      r_beat_cnt <= '0;
    end else if (w_accept) begin
      r_beat_cnt <= r_beat_cnt + 1'b1;
    end
  end

  assign sel        = r_sel;
  assign gnt        = r_gnt;
  assign out_valid  = r_valid;
  assign burst_done = w_last;

endmodule
`default_nettype wire

// File: doc/mux_rr_scheduler.md
Name: mux_rr_scheduler

Overview:
- Round-robin scheduler that shares the 31-input, 2-bit-wide selection mux among 31 requesters.
- Drives the mux's 5-bit select and a one-hot grant vector, and holds each grant for a configurable burst of beats.
- Presents the selected stream to one downstream consumer over a valid/ready handshake.
- Sits between the requester array and the mux; the mux data path stays combinational and unchanged.

Parameters:
- NUM_REQ, 31: number of requesters; fixed to the mux input count.
- SEL_W, 5: select width; must satisfy 2^SEL_W > NUM_REQ.
- HOLD_W, 2: width of the burst-length config; max burst is 2^HOLD_W beats.
- IDLE_SEL, 5'b11111: select code driven when nothing is granted. This is the unused mux code, so the mux outputs 0.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  per-requester request; must stay high for the whole burst.
- arb_en  input  1  1 = new grants allowed; 0 = in-flight burst completes and no new grant is issued.
- cfg_hold  input  HOLD_W  burst length minus 1, latched at grant time.
- out_ready  input  1  downstream ready.
- sel  output  SEL_W  registered mux select.
- gnt  output  NUM_REQ  registered one-hot grant; bit i = 1 iff sel == i.
- out_valid  output  1  registered; mux output is valid this cycle.
- burst_done  output  1  single-cycle pulse on the final accepted beat of a burst.

Behaviour:
- Reset (async assert, sync-to-clk deassert handled upstream):
  - sel = IDLE_SEL, gnt = 0, out_valid = 0, burst_done = 0.
  - Internal: state = IDLE, ptr = 0, beat_cnt = 0, hold_q = 0.
  - Reset asserted mid-burst aborts the burst immediately; no completion pulse.
- State machine: IDLE, GRANT.
- Arbitration (combinational):
  - Candidate set = req, with the current grantee masked off when leaving GRANT.
  - Winner = first set index at or above ptr, searching upward and wrapping 30 -> 0.
  - No winner, or arb_en = 0, means no grant.
- IDLE:
  - out_valid = 0, sel = IDLE_SEL.
  - If a winner exists: next cycle state = GRANT, sel = winner, gnt = one-hot(winner), out_valid = 1, hold_q = cfg_hold, beat_cnt = 0, ptr = (winner + 1) mod 31.
  - Latency: req rising in cycle N gives sel/out_valid in cycle N+1.
- GRANT:
  - sel, gnt and hold_q stay stable; cfg_hold changes are ignored.
  - Beat accepted = out_valid & out_ready; each accepted beat increments beat_cnt.
  - out_ready = 0 holds everything, with no timeout.
- Normal release: accepted beat with beat_cnt == hold_q.
  - burst_done = 1 that same cycle (combinational from the registered state).
  - Back-to-back: if the arbiter has a winner among the other requesters, the next cycle is GRANT to the new winner with no bubble.
  - Otherwise the next cycle is IDLE.
- Abort release: req[sel] = 0 while in GRANT.
  - Release at the next edge; burst_done is not pulsed.
  - A beat accepted in the same cycle still counts.
- arb_en = 0 during GRANT: the current burst completes normally, then IDLE regardless of pending requests.
- Single requester: a continuously asserted requester is re-granted after release only through IDLE. It is masked in the release cycle, so there is exactly one idle bubble between its own consecutive bursts.
- ptr wraps: a grant to 30 sets ptr = 0.
- req bits change freely; only req[sel] is sampled while in GRANT.

Test Plan:
1. Reset: drive rst_n = 0 mid-simulation with req = all ones -> sel = 31, gnt = 0, out_valid = 0, burst_done = 0, asynchronously, before the next clk edge.
2. Single burst: req[5] = 1, cfg_hold = 2, out_ready = 1, arb_en = 1 -> sel = 5 and gnt = 0x20 for exactly 3 cycles, burst_done high on the 3rd, then sel = 31, then a re-grant to 5 after one bubble.
3. Round-robin wrap: req[0] and req[30] held, cfg_hold = 0, ptr = 0 -> grant order 0, 30, 0, 30 back-to-back with out_valid continuously 1.
4. Backpressure: grant to 12, cfg_hold = 1, out_ready toggling 0,0,1,0,1 -> sel = 12 stable throughout; burst_done on the 5th cycle only.
5. Abort: grant to 7, cfg_hold = 3, req[7] drops after 1 accepted beat -> out_valid = 0 next cycle, no burst_done; a pending req[9] is granted next instead.
6. arb_en = 0 mid-burst with req[3] pending -> the current burst finishes, then IDLE; re-asserting arb_en grants 3 one cycle later.
